// File: rtl/rob_retire_ctl_if.sv
// rtl/rob_retire_ctl_if.sv - ROB head slots, register-file write ports and recovery signals of rob_retire_ctl
// master: the retire controller; slave: the ROB / register file / fetch side.
interface rob_retire_ctl_if #(
  parameter int DEPTH        = 16,
  parameter int EXT_COUNT    = 4,
  parameter int DEPTHLOG2    = $clog2(DEPTH),
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
);
  logic [EXT_COUNT-1:0]         slot_valid;
  logic [EXT_COUNT-1:0][4:0]    slot_dest_reg;
  logic [EXT_COUNT-1:0]         slot_dest_vld;
  logic [EXT_COUNT-1:0][31:0]   slot_result;
  logic [EXT_COUNT-1:0]         slot_mispred;
  logic [EXT_COUNT-1:0][31:0]   slot_target;
  logic [DEPTHLOG2-1:0]         head_idx;
  logic [EXTCOUNTLOG2-1:0]      retire_limit;

  logic                         consume;
  logic [EXTCOUNTLOG2-1:0]      consume_count;
  logic [EXT_COUNT-1:0]         rf_we;
  logic [EXT_COUNT-1:0][4:0]    rf_waddr;
  logic [EXT_COUNT-1:0][31:0]   rf_wdata;
  logic                         flush;
  logic [DEPTHLOG2-1:0]         flush_idx;
  logic                         redirect_vld;
  logic [31:0]                  redirect_pc;
  logic                         frontend_hold;

  modport master (
    input  slot_valid, slot_dest_reg, slot_dest_vld, slot_result, slot_mispred, slot_target,
           head_idx, retire_limit,
    output consume, consume_count, rf_we, rf_waddr, rf_wdata, flush, flush_idx,
           redirect_vld, redirect_pc, frontend_hold
  );

  modport slave (
    output slot_valid, slot_dest_reg, slot_dest_vld, slot_result, slot_mispred, slot_target,
           head_idx, retire_limit,
    input  consume, consume_count, rf_we, rf_waddr, rf_wdata, flush, flush_idx,
           redirect_vld, redirect_pc, frontend_hold
  );
endinterface

// File: rtl/rob_retire_ctl.sv
// rtl/rob_retire_ctl.sv - ROB commit sequencer: in-order multi-retire plus mispredict recovery
// Optional feature macro RETIRE_PERF_EN: retire and flush counters on perf_retired_o / perf_flushes_o.
module rob_retire_ctl #(
  parameter int DEPTH        = 16,
  parameter int EXT_COUNT    = 4,
  parameter int DEPTHLOG2    = $clog2(DEPTH),
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  rob_retire_ctl_if.master        bus,
  output logic [31:0]             perf_retired_o,
  output logic [31:0]             perf_flushes_o
);

  localparam int NW = $clog2(EXT_COUNT + 1);

  typedef enum logic [1:0] {RUN, WAIT_BDS, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [DEPTHLOG2-1:0]    br_idx_q, br_idx_d;
  logic [31:0]             tgt_q, tgt_d;

  logic [NW-1:0]           n;
  logic                    stop;
  logic                    br_found;
  logic                    bds_retired;
  logic [EXTCOUNTLOG2-1:0] br_pos;
  logic [EXTCOUNTLOG2-1:0] limit;
  logic [DEPTHLOG2-1:0]    br_slot_idx;

  logic                    flush_d;
  logic [DEPTHLOG2-1:0]    flush_idx_d;
  logic                    redirect_d;
  logic                    hold_d;
  logic [EXT_COUNT-1:0]    rf_we_d;

  // Retire scan; while waiting for a delay slot only slot 0 may retire and
  // a mispredict flag on it is ignored.
  always_comb begin
    n           = '0;
    stop        = 1'b0;
    br_found    = 1'b0;
    bds_retired = 1'b0;
    br_pos      = '0;
    limit       = (state_q == WAIT_BDS) ? '0 : bus.retire_limit;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!stop) begin
        if (state_q != FLUSH && i <= int'(limit) && bus.slot_valid[i]) begin
          n = NW'(i + 1);
          if (br_found) begin
            bds_retired = 1'b1;
            stop        = 1'b1;
          end else if (state_q == RUN && bus.slot_mispred[i]) begin
            br_found = 1'b1;
            br_pos   = EXTCOUNTLOG2'(i);
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  assign br_slot_idx = bus.head_idx + DEPTHLOG2'(br_pos);

  always_comb begin
    state_d     = state_q;
    br_idx_d    = br_idx_q;
    tgt_d       = tgt_q;
    flush_d     = 1'b0;
    flush_idx_d = '0;
    redirect_d  = 1'b0;
    hold_d      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (br_found) begin
          tgt_d    = bus.slot_target[br_pos];
          br_idx_d = br_slot_idx;
          if (bds_retired) begin
            flush_d     = 1'b1;
            flush_idx_d = br_slot_idx;
            state_d     = FLUSH;
          end else begin
            state_d = WAIT_BDS;
          end
        end
      end
      WAIT_BDS: begin
        hold_d = 1'b1;
        if (bus.slot_valid[0]) begin
          flush_d     = 1'b1;
          flush_idx_d = br_idx_q;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        hold_d     = 1'b1;
        redirect_d = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rf_we_d = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      rf_we_d[i] = (i < int'(n)) && bus.slot_dest_vld[i] && (bus.slot_dest_reg[i] != 5'd0);
    end
  end

  // n is already zero in FLUSH, so consume and rf_we drop there without extra gating.
  assign bus.consume       = (n != '0);
  assign bus.consume_count = EXTCOUNTLOG2'(n - 1'b1);
  assign bus.rf_we         = rf_we_d;
  assign bus.rf_waddr      = bus.slot_dest_reg;
  assign bus.rf_wdata      = bus.slot_result;
  assign bus.flush         = flush_d;
  assign bus.flush_idx     = flush_idx_d;
  assign bus.redirect_vld  = redirect_d;
  assign bus.redirect_pc   = tgt_q;
  assign bus.frontend_hold = hold_d;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= RUN;
      br_idx_q <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      br_idx_q <= br_idx_d;
      tgt_q    <= tgt_d;
    end
  end

`ifdef RETIRE_PERF_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (bus.consume) perf_retired_q <= perf_retired_q + 32'(n);
      if (flush_d)     perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_flushes_o = perf_flushes_q;
`else
  assign perf_retired_o = '0;
  assign perf_flushes_o = '0;
`endif

endmodule

// File: tb/tb_rob_retire_ctl.sv
// tb/tb_rob_retire_ctl.sv - scoreboard bench for rob_retire_ctl with a behavioural retire/recovery model
module tb_rob_retire_ctl;
  localparam int DEPTH = 16;
  localparam int EXT   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_retire_ctl_if #(.DEPTH(DEPTH), .EXT_COUNT(EXT)) bus ();
  logic [31:0] perf_ret, perf_fl;

  rob_retire_ctl #(.DEPTH(DEPTH), .EXT_COUNT(EXT)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .bus            (bus),
    .perf_retired_o (perf_ret),
    .perf_flushes_o (perf_fl)
  );

  typedef struct {
    bit              consume;
    int              count;
    bit [3:0]        we;
    bit [3:0][4:0]   waddr;
    bit [3:0][31:0]  wdata;
    bit              flush;
    int              flush_idx;
    bit              redir;
    bit [31:0]       rpc;
    bit              hold;
    bit [31:0]       pret;
    bit [31:0]       pfl;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int n_checks = 0;
  int n_errors = 0;

  // stimulus values for the current cycle
  bit [3:0]       v, dv, mp;
  bit [3:0][4:0]  dr;
  bit [3:0][31:0] res, tg;
  int             head, lim;

  // model of the recovery sequence
  bit        m_wait_bds, m_redirect_due;
  int        m_br_idx;
  bit [31:0] m_tgt;
  bit [31:0] m_ret, m_fl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive();
    bus.slot_valid    = v;
    bus.slot_dest_vld = dv;
    bus.slot_mispred  = mp;
    bus.slot_dest_reg = dr;
    bus.slot_result   = res;
    bus.slot_target   = tg;
    bus.head_idx      = 4'(head);
    bus.retire_limit  = 2'(lim);
  endtask

  task automatic model_reset();
    m_wait_bds = 0; m_redirect_due = 0; m_br_idx = 0; m_tgt = '0; m_ret = '0; m_fl = '0;
  endtask

  // Drive the cycle's inputs and queue what the outputs must be.
  task automatic issue();
    exp_t e;
    int n, maxw, br;
    bit bds, done;
    drive();
    n = 0; br = -1; bds = 0; done = 0;
    maxw = m_redirect_due ? 0 : (m_wait_bds ? 1 : lim + 1);
    while (!done && n < maxw && v[n]) begin
      n++;
      if (br >= 0) begin
        bds = 1; done = 1;
      end else if (!m_wait_bds && mp[n-1]) begin
        br = n - 1;
      end
    end
    e.consume = (n > 0);
    e.count   = (n - 1) & 3;
    for (int i = 0; i < EXT; i++) e.we[i] = (i < n) && dv[i] && (dr[i] != 0);
    e.waddr = dr;
    e.wdata = res;
    e.flush = (br >= 0 && bds) || (m_wait_bds && n == 1);
    e.flush_idx = m_wait_bds ? m_br_idx : (head + br) % DEPTH;
    e.redir = m_redirect_due;
    e.rpc   = m_tgt;
    e.hold  = m_wait_bds || m_redirect_due;
`ifdef RETIRE_PERF_EN
    e.pret = m_ret;
    e.pfl  = m_fl;
`else
    e.pret = '0;
    e.pfl  = '0;
`endif
    exp_q.push_back(e);
    m_ret += n;
    if (e.flush) m_fl += 1;
    if (m_redirect_due) begin
      m_redirect_due = 0;
    end else if (m_wait_bds) begin
      if (n == 1) begin
        m_wait_bds = 0; m_redirect_due = 1;
      end
    end else if (br >= 0) begin
      m_tgt    = tg[br];
      m_br_idx = (head + br) % DEPTH;
      if (bds) m_redirect_due = 1;
      else     m_wait_bds = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    issue();
  endtask

  task automatic idle();
    v = '0; mp = '0;
    cyc();
  endtask

  task automatic randomize_slots();
    for (int i = 0; i < EXT; i++) begin
      v[i]   = ($urandom_range(3) != 0);
      mp[i]  = ($urandom_range(5) == 0);
      dv[i]  = $urandom_range(1);
      dr[i]  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      res[i] = $urandom;
      tg[i]  = $urandom;
    end
    if ($urandom_range(15) == 0) v = '0;
    head = $urandom_range(DEPTH - 1);
    lim  = $urandom_range(3);
  endtask

  // monitor: compares every cycle that has a queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("consume", bus.consume, me.consume);
        if (me.consume) chk("consume_count", bus.consume_count, me.count);
        chk("rf_we", bus.rf_we, me.we);
        for (int i = 0; i < EXT; i++) begin
          if (me.we[i]) begin
            chk("rf_waddr", bus.rf_waddr[i], me.waddr[i]);
            chk("rf_wdata", bus.rf_wdata[i], me.wdata[i]);
          end
        end
        chk("flush", bus.flush, me.flush);
        if (me.flush) chk("flush_idx", bus.flush_idx, me.flush_idx);
        chk("redirect_vld", bus.redirect_vld, me.redir);
        if (me.redir) chk("redirect_pc", bus.redirect_pc, me.rpc);
        chk("frontend_hold", bus.frontend_hold, me.hold);
        chk("perf_retired", perf_ret, me.pret);
        chk("perf_flushes", perf_fl, me.pfl);
      end
    end
  end

  initial begin
    v = '0; dv = '0; mp = '0; dr = '0; res = '0; tg = '0; head = 0; lim = 3;
    drive();
    model_reset();
    #2;
    chk("reset consume", bus.consume, 1'b0);
    chk("reset flush", bus.flush, 1'b0);
    chk("reset redirect_vld", bus.redirect_vld, 1'b0);
    chk("reset redirect_pc", bus.redirect_pc, 32'd0);
    chk("reset hold", bus.frontend_hold, 1'b0);
    chk("reset rf_we", bus.rf_we, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // plain full-width retire, reg 0 never written
    head = 0; lim = 3; v = 4'b1111; mp = '0; dv = 4'b1011;
    dr = {5'd9, 5'd0, 5'd4, 5'd0};
    res = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
    cyc();
    // hole at slot 2, empty head, narrowed width
    v = 4'b1011; dr = {5'd9, 5'd6, 5'd4, 5'd2}; cyc();
    v = 4'b1110; cyc();
    lim = 1; v = 4'b1111; cyc();
    // branch + delay slot retire together across the index wrap
    head = 14; lim = 3; v = 4'b0111; mp = 4'b0010; tg[1] = 32'h0040_0100; cyc();
    idle();
    // branch at the width bound, delay slot arrives later
    head = 3; lim = 3; v = 4'b1111; mp = 4'b1000; tg[3] = 32'h0000_8844; cyc();
    idle();
    idle();
    v = 4'b1111; mp = 4'b0001; cyc();
    idle();
    // branch with no delay slot yet, then async reset in the wait
    head = 7; lim = 0; v = 4'b0001; mp = 4'b0001; tg[0] = 32'h1234_5678; cyc();
    idle();
    @(posedge clk);
    #1;
    v = '0; mp = '0;
    drive();
    rst_n = 1'b0;
    #1;
    chk("mid-recovery reset hold", bus.frontend_hold, 1'b0);
    chk("mid-recovery reset flush", bus.flush, 1'b0);
    chk("mid-recovery reset redirect", bus.redirect_vld, 1'b0);
    chk("mid-recovery reset consume", bus.consume, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v = 4'b0001; mp = '0; head = 8; lim = 3; cyc();
    idle();

    for (int k = 0; k < 3000; k++) begin
      randomize_slots();
      cyc();
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
